filtro_ctrl: RTL and testbench

FILTRO_CTRL -- requirements
Module: filtro_ctrl

---
 rtl/filtro_pkg.sv | 19 +
 rtl/filtro_coef_bank.sv | 42 ++++
 rtl/filtro_ctrl.sv | 109 ++++++++++
 tb/tb_filtro_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// filtro_pkg: Q4.14 format constants, controller state encoding and coefficient addresses
package filtro_pkg;
  localparam int SIZE = 19;
  localparam int PF = 14;
  localparam int MAG = 4;
  localparam int NCOEF = 5;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_OUT    = 3'd4
  } state_t;
  localparam logic [2:0] ADDR_A1 = 3'd0;
  localparam logic [2:0] ADDR_A2 = 3'd1;
  localparam logic [2:0] ADDR_B0 = 3'd2;
  localparam logic [2:0] ADDR_B1 = 3'd3;
  localparam logic [2:0] ADDR_B2 = 3'd4;
endpackage

// File: rtl/filtro_coef_bank.sv
// filtro_coef_bank: shadow coefficient bank written by the host, copied to the active bank on load
module filtro_coef_bank #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [2:0]   addr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         load_i,
  output logic [W-1:0] a1_o,
  output logic [W-1:0] a2_o,
  output logic [W-1:0] b0_o,
  output logic [W-1:0] b1_o,
  output logic [W-1:0] b2_o
);
  import filtro_pkg::*;
  logic [W-1:0] shadow_q [NCOEF];
  logic [W-1:0] shadow_d [NCOEF];
  logic [W-1:0] active_q [NCOEF];
  // apply this cycle's write first so a coincident load copies it; addresses 5-7 match nothing
  always_comb begin
    for (int k = 0; k < NCOEF; k++) shadow_d[k] = (we_i && addr_i == 3'(k)) ? wdata_i : shadow_q[k];
  end
  // shadow always follows writes, active only changes on load
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCOEF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
      if (load_i) active_q <= shadow_d;
    end
  end
  assign a1_o = active_q[ADDR_A1];
  assign a2_o = active_q[ADDR_A2];
  assign b0_o = active_q[ADDR_B0];
  assign b1_o = active_q[ADDR_B1];
  assign b2_o = active_q[ADDR_B2];
endmodule

// File: rtl/filtro_ctrl.sv
// filtro_ctrl: sample-rate sequencer driving the ADC, the filter step enable and output capture
module filtro_ctrl #(
  parameter int SIZE        = 19,
  parameter int SAMPLE_DIV  = 2500,
  parameter int SETTLE      = 4,
  parameter int ADC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  output logic            adc_start,
  input  logic            adc_done,
  input  logic [SIZE-1:0] adc_data,
  output logic [SIZE-1:0] u,
  output logic            en,
  input  logic [SIZE-1:0] y_in,
  output logic [SIZE-1:0] y_out,
  output logic            y_valid,
  input  logic            coef_we,
  input  logic [2:0]      coef_addr,
  input  logic [SIZE-1:0] coef_wdata,
  input  logic            coef_commit,
  output logic [SIZE-1:0] a1,
  output logic [SIZE-1:0] a2,
  output logic [SIZE-1:0] b0,
  output logic [SIZE-1:0] b1,
  output logic [SIZE-1:0] b2,
  input  logic            err_clr,
  output logic            busy,
  output logic            timeout_err,
  output logic            overrun_err
);
  import filtro_pkg::*;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  state_t state_q, state_d;
  logic [DW-1:0] div_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [SIZE-1:0] u_q, y_out_q;
  logic y_valid_q, pend_q, tout_q, ovr_q;
  logic tick, accept, timeout, start_conv, load;
  assign tick       = div_q == DW'(SAMPLE_DIV - 1);
  assign accept     = state_q == ST_CONV && adc_done;
  assign timeout    = state_q == ST_CONV && !adc_done && tcnt_q == TW'(ADC_TIMEOUT - 1);
  assign start_conv = state_q == ST_IDLE && tick;
  assign load       = start_conv && (pend_q || coef_commit);
  // sequence one sample: convert, let the filter settle, step it, capture its output
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = tick ? ST_CONV : ST_IDLE;
      ST_CONV:   state_d = accept ? ST_SETTLE : timeout ? ST_IDLE : ST_CONV;
      ST_SETTLE: state_d = scnt_q == SW'(SETTLE - 1) ? ST_STEP : ST_SETTLE;
      ST_STEP:   state_d = ST_OUT;
      ST_OUT:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    tcnt_d = (state_q == ST_CONV && state_d == ST_CONV) ? tcnt_q + 1'b1 : '0;
    scnt_d = (state_q == ST_SETTLE && state_d == ST_SETTLE) ? scnt_q + 1'b1 : '0;
  end
  // state, free-running divider, sample/output registers and sticky flags (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      u_q       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      pend_q    <= 1'b0;
      tout_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= tick ? '0 : div_q + 1'b1;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      u_q       <= accept ? adc_data : u_q;
      y_out_q   <= state_q == ST_OUT ? y_in : y_out_q;
      y_valid_q <= state_q == ST_OUT;
      pend_q    <= start_conv ? 1'b0 : pend_q | coef_commit;
      tout_q    <= timeout | (tout_q & ~err_clr);
      ovr_q     <= (tick && state_q != ST_IDLE) | (ovr_q & ~err_clr);
    end
  end
  assign adc_start   = state_q == ST_CONV && tcnt_q == '0;
  assign en          = state_q == ST_STEP;
  assign busy        = state_q != ST_IDLE;
  assign u           = u_q;
  assign y_out       = y_out_q;
  assign y_valid     = y_valid_q;
  assign timeout_err = tout_q;
  assign overrun_err = ovr_q;
  filtro_coef_bank #(.W(SIZE)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (coef_we),
    .addr_i  (coef_addr),
    .wdata_i (coef_wdata),
    .load_i  (load),
    .a1_o    (a1),
    .a2_o    (a2),
    .b0_o    (b0),
    .b1_o    (b1),
    .b2_o    (b2)
  );
endmodule

// File: tb/tb_filtro_ctrl.sv
// tb_filtro_ctrl: directed scoreboard bench for filtro_ctrl with a one-tap filter model
module tb_filtro_ctrl;
  logic clk, rst;
  logic adc_done, coef_we, coef_commit, err_clr;
  logic [18:0] adc_data, coef_wdata, y_m;
  logic [2:0] coef_addr;
  logic adc_start, en, y_valid, busy, timeout_err, overrun_err;
  logic [18:0] u, y_out, a1, a2, b0, b1, b2;
  logic adc_start2, en2, y_valid2, busy2, timeout_err2, overrun_err2;
  logic [18:0] u2, y_out2, a1_2, a2_2, b0_2, b1_2, b2_2;
  logic signed [37:0] prod;
  logic [18:0] exp_q [$];
  int vectors = 0, errs = 0, en_cnt = 0, n, m, en_before;

  filtro_ctrl #(.SIZE(19), .SAMPLE_DIV(20), .SETTLE(2), .ADC_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .u(u), .en(en), .y_in(y_m), .y_out(y_out), .y_valid(y_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2), .err_clr(err_clr), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err));

  filtro_ctrl #(.SIZE(19), .SAMPLE_DIV(20), .SETTLE(2), .ADC_TIMEOUT(30)) dut2 (
    .clk(clk), .rst(rst), .adc_start(adc_start2), .adc_done(adc_done), .adc_data(adc_data),
    .u(u2), .en(en2), .y_in(y_m), .y_out(y_out2), .y_valid(y_valid2),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .a1(a1_2), .a2(a2_2), .b0(b0_2), .b1(b1_2), .b2(b2_2), .err_clr(err_clr), .busy(busy2),
    .timeout_err(timeout_err2), .overrun_err(overrun_err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prod = $signed(b0) * $signed(u);
  always_ff @(posedge clk) begin
    if (rst) y_m <= '0;
    else if (en) y_m <= prod[32:14];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (en) en_cnt++;
    if (y_valid) begin
      if (exp_q.size() == 0) chk("y_valid_unexpected", 32'(y_valid), 32'd0);
      else chk("y_out", 32'(y_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1; adc_done = 0; adc_data = '0; coef_we = 0; coef_addr = '0; coef_wdata = '0;
    coef_commit = 0; err_clr = 0;
    repeat (3) cyc();
    chk("rst_u", 32'(u), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_adc_start", 32'(adc_start), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_y_out", 32'(y_out), 0);
    chk("rst_b0", 32'(b0), 0);
    chk("rst_flags", {timeout_err, overrun_err}, 0);
    // basic path
    rst = 0; n = 0;
    coef_we = 1; coef_addr = 3'd2; coef_wdata = 19'd16384; cyc(); n++;
    coef_we = 0; coef_commit = 1; cyc(); n++; coef_commit = 0;
    chk("b0_shadow_only", 32'(b0), 0);
    while (!adc_start && n < 40) begin cyc(); n++; end
    chk("first_tick_latency", n, 20);
    chk("b0_committed", 32'(b0), 16384);
    chk("busy_conv", 32'(busy), 1);
    repeat (3) cyc();
    chk("adc_start_once", 32'(adc_start), 0);
    adc_done = 1; adc_data = 19'd8192; exp_q.push_back(19'd8192); cyc(); adc_done = 0;
    chk("u_load", 32'(u), 8192);
    chk("en_settle1", 32'(en), 0);
    cyc(); chk("en_settle2", 32'(en), 0);
    cyc(); chk("en_step", 32'(en), 1);
    cyc(); chk("en_out", 32'(en), 0);
    chk("y_valid_early", 32'(y_valid), 0);
    cyc(); chk("y_valid_pulse", 32'(y_valid), 1);
    cyc(); chk("y_valid_once", 32'(y_valid), 0);
    chk("busy_idle", 32'(busy), 0);
    // timeout, overrun and shadow isolation
    m = 0;
    while (!adc_start && m < 20) begin cyc(); m++; end
    chk("sample_period", m, 11);
    en_before = en_cnt;
    repeat (7) cyc();
    chk("conv_k7_busy", 32'(busy), 1);
    cyc();
    chk("timeout_idle", 32'(busy), 0);
    chk("timeout_err", 32'(timeout_err), 1);
    chk("timeout_u", 32'(u), 8192);
    chk("timeout_no_en", en_cnt, en_before);
    chk("dut2_still_conv", 32'(busy2), 1);
    repeat (11) cyc();
    chk("ovr_before_tick", 32'(overrun_err2), 0);
    cyc();
    chk("ovr_set", 32'(overrun_err2), 1);
    chk("ovr_dut_clear", 32'(overrun_err), 0);
    chk("period_kept", 32'(adc_start), 1);
    cyc(); cyc();
    coef_we = 1; coef_addr = 3'd3; coef_wdata = 19'h7FFFF; cyc();
    coef_we = 0; coef_commit = 1; cyc(); coef_commit = 0;
    repeat (3) cyc();
    err_clr = 1; cyc();
    chk("set_wins", 32'(timeout_err), 1);
    chk("b1_isolated", 32'(b1), 0);
    cyc(); err_clr = 0;
    chk("err_clr_timeout", 32'(timeout_err), 0);
    chk("err_clr_ovr", 32'(overrun_err2), 0);
    cyc();
    chk("dut2_timeout", 32'(timeout_err2), 1);
    chk("b1_still_old", 32'(b1), 0);
    m = 0;
    while (!adc_start && m < 20) begin cyc(); m++; end
    chk("period_after_timeout", m, 10);
    chk("b1_committed", 32'(b1), 32'h7FFFF);
    chk("dut2_start_no_stall", 32'(adc_start2), 1);
    // done in the first CONV cycle, then reset during STEP
    adc_done = 1; adc_data = 19'h5A5A5; cyc(); adc_done = 0;
    chk("u_first_cycle_done", 32'(u), 32'h5A5A5);
    cyc(); cyc();
    chk("en_before_rst", 32'(en), 1);
    rst = 1; cyc();
    chk("rst_step_en", 32'(en), 0);
    chk("rst_step_y_valid", 32'(y_valid), 0);
    chk("rst_step_u", 32'(u), 0);
    chk("rst_step_y_out", 32'(y_out), 0);
    chk("rst_step_b1", 32'(b1), 0);
    chk("rst_step_busy", 32'(busy), 0);
    chk("rst_step_flags", {timeout_err, overrun_err, timeout_err2, overrun_err2}, 0);
    rst = 0;
    repeat (3) cyc();
    chk("no_valid_after_rst", 32'(y_valid), 0);
    // write + commit collision, ignored address
    coef_we = 1; coef_addr = 3'd2; coef_wdata = 19'd100; coef_commit = 1; cyc();
    coef_we = 0; coef_commit = 0;
    m = 0;
    while (!adc_start && m < 40) begin cyc(); m++; end
    chk("tick_after_rst", 32'(adc_start), 1);
    chk("collision_b0", 32'(b0), 100);
    chk("collision_others", {13'd0, a1 | a2 | b1 | b2}, 0);
    adc_done = 1; adc_data = 19'h7E000; exp_q.push_back(19'h7FFCE); cyc(); adc_done = 0;
    coef_we = 1; coef_addr = 3'd6; coef_wdata = 19'h3FFFF; coef_commit = 1; cyc();
    coef_we = 0; coef_commit = 0;
    m = 0;
    while (!y_valid && m < 10) begin cyc(); m++; end
    chk("neg_sample_valid", 32'(y_valid), 1);
    m = 0;
    while (!adc_start && m < 25) begin cyc(); m++; end
    chk("tick_after_addr6", 32'(adc_start), 1);
    chk("addr6_b0", 32'(b0), 100);
    chk("addr6_others", {13'd0, a1 | a2 | b1 | b2}, 0);
    repeat (2) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
